int_issue_queue: RTL and testbench
==================================

// Module: int_issue_queue
// PURPOSE
//  Receive end of the dispatch->issue handshake: accepts one renamed instr/cycle (payload, pregs, robidx).
//  Holds entries until both sources are ready, then issues the oldest ready entry to the execute stage.
//  Tracks source readiness via writeback wakeup; drops wrong-path entries on redirect flush.
// PARAMETERS
//  DEPTH      8    queue entries (power of 2, >=2)
//  PREG_W     6    physical register index width (matches `PREG_RANGE)
//  ROB_W      6    robidx width (matches `ROB_SIZE_LOG)
//  PAYLOAD_W  192  opaque bundle: pc, instr, imm, alu/muldiv/cx type, ls_size, flags; never decoded here
// PORTS
//  clock            in   1          single clock
//  reset            in   1          synchronous, active-high
//  enq_valid        in   1          dispatch offers an instr
//  enq_ready        out  1          queue accepts this cycle
//  enq_payload      in   PAYLOAD_W  opaque payload
//  enq_src1_is_reg  in   1          src1 reads a preg
//  enq_src2_is_reg  in   1          src2 reads a preg
//  enq_prs1/prs2    in   PREG_W     source pregs
//  enq_prd          in   PREG_W     dest preg (passed through)
//  enq_src1_state   in   1          busytable: prs1 value already written
//  enq_src2_state   in   1          busytable: prs2 value already written
//  enq_robidx_flag  in   1          rob wrap flag
//  enq_robidx       in   ROB_W      rob index
//  wb0_valid/wb1_valid in 1         writeback broadcast
//  wb0_prd/wb1_prd  in   PREG_W     preg being written
//  iss_valid        out  1          entry selected for execute
//  iss_ready        in   1          execute accepts
//  iss_payload/iss_prs1/iss_prs2/iss_prd/iss_src1_is_reg/iss_src2_is_reg/iss_robidx_flag/iss_robidx  out  as enq
//  flush_valid      in   1          redirect
//  flush_robidx_flag in  1 ; flush_robidx in ROB_W   redirecting instr (itself kept)
// BEHAVIOUR
//  - Reset: all entry valid bits 0; iss_valid=0; enq_ready=0 while reset high, 1 first cycle after.
//  - enq_ready = (free entry exists) & ~flush_valid. Enqueue on enq_valid&enq_ready into lowest free slot.
//  - Src ready at enq = ~is_reg | prs==0 | state | (wbN_valid & wbN_prd==prs, either port).
//  - Wakeup: each cycle any valid entry with prsX==wbN_prd & wbN_valid sets srcX_rdy (reg'd, next cycle).
//  - Select: combinational; among valid entries with both rdy, pick oldest by robidx age.
//    older(a,b) = (a.flag==b.flag) ? a.idx<b.idx : a.idx>b.idx. iss_* driven from selected entry.
//  - iss_valid = any_ready & ~flush_valid. On iss_valid&iss_ready entry freed at clock edge; its slot
//    is enqueueable the following cycle (no same-cycle free->alloc).
//  - Latency: enq with ready srcs -> earliest iss_valid next cycle. Wakeup -> issuable next cycle.
//  - Flush: entries strictly younger than flush robidx invalidated at edge; older/equal kept; no enq/issue
//    that cycle. Wakeups still applied to surviving entries.
//  - Full: enq_ready=0 until an issue frees a slot. Empty: iss_valid=0.
//  - Robidx wrap handled solely by flag compare; DEPTH < 2^ROB_W so no ambiguity.
//  - iss_valid held with stable iss_* while iss_ready=0 unless an older entry becomes ready (reselect allowed).
// CONFIGURATION
//  ISQ_BYPASS_EN defined: when queue empty and enq srcs ready, enq drives iss_* same cycle;
//   if iss_ready, instr issues without allocating (0-cycle); else allocates normally.
//  Undefined: every instr allocates; minimum enq->iss latency 1 cycle.
// STRUCTURE
//  - DEPTH, PREG_W, ROB_W, PAYLOAD_W defaults and isq entry typedef (valid, rdy1/2, pregs, robidx,
//    payload) live in defines.sv with `ROB_SIZE_LOG/`PREG_RANGE.
//  - Sub-module robidx_older_cmp (flag+idx age compare), reused by select tree and flush mask.
// TESTING
//  - Reset mid-run with 5 valid entries: cycle after reset low -> iss_valid=0, enq_ready=1, no stale issue.
//  - Enq robidx 3 (srcs ready), iss_ready=1 -> iss_valid next cycle, iss_robidx=3; queue empty after.
//  - Enq prs1=12 not ready; wb0 prd=12 two cycles later -> issues cycle after wakeup, not before.
//  - Fill 8 entries -> enq_ready=0; one issue -> enq_ready=1 next cycle; 9th instr accepted.
//  - Entries robidx {flag1:1, flag0:62, flag0:60}, all ready -> issue order 60, 62, then 1 (wrap).
//  - Entries robidx 4,5,7,9; flush robidx 5 -> only 4,5 remain; iss_valid=0 in flush cycle.

Source files
------------

// File: rtl/int_issue_queue_pkg.sv
// Shared widths, the queue entry record and the dispatch-time source readiness rule
// for the integer issue queue.
package int_issue_queue_pkg;

  localparam int ISQ_DEPTH = 8;
  localparam int PREG_W    = 6;
  localparam int ROB_W     = 6;
  localparam int PAYLOAD_W = 192;

  typedef struct packed {
    logic                 valid;
    logic                 rdy1;
    logic                 rdy2;
    logic                 src1_is_reg;
    logic                 src2_is_reg;
    logic [PREG_W-1:0]    prs1;
    logic [PREG_W-1:0]    prs2;
    logic [PREG_W-1:0]    prd;
    logic                 robidx_flag;
    logic [ROB_W-1:0]     robidx;
    logic [PAYLOAD_W-1:0] payload;
  } isq_entry_t;

  // preg 0 is hardwired and always readable; a same-cycle writeback also counts as ready.
  function automatic logic src_ready_at_enq(
    input logic              is_reg,
    input logic [PREG_W-1:0] prs,
    input logic              state,
    input logic              wb0_v,
    input logic [PREG_W-1:0] wb0_p,
    input logic              wb1_v,
    input logic [PREG_W-1:0] wb1_p
  );
    return !is_reg || (prs == '0) || state ||
           (wb0_v && (wb0_p == prs)) || (wb1_v && (wb1_p == prs));
  endfunction

endpackage

// File: rtl/int_issue_queue_robidx_older_cmp.sv
// ROB age compare: o_older is 1 when (a_flag, a_idx) is strictly older than (b_flag, b_idx).
module robidx_older_cmp
  import int_issue_queue_pkg::*;
(
  input  logic             i_a_flag,
  input  logic [ROB_W-1:0] i_a_idx,
  input  logic             i_b_flag,
  input  logic [ROB_W-1:0] i_b_idx,
  output logic             o_older
);

  // Differing flags mean one side has wrapped, so the larger index is the older one.
  assign o_older = (i_a_flag == i_b_flag) ? (i_a_idx < i_b_idx) : (i_a_idx > i_b_idx);

endmodule

// File: rtl/int_issue_queue.sv
// Integer issue queue: holds renamed instrs until both sources are ready, issues oldest-ready first.
// Optional `define ISQ_BYPASS_EN lets an instr entering an empty queue with ready sources issue the same cycle.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH = ISQ_DEPTH
) (
  input  logic                 clock,
  input  logic                 reset,
  // Handshakes: a transfer happens on a cycle where valid & ready are both 1; valid never waits on ready.
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [PAYLOAD_W-1:0] enq_payload,
  input  logic                 enq_src1_is_reg,
  input  logic                 enq_src2_is_reg,
  input  logic [PREG_W-1:0]    enq_prs1,
  input  logic [PREG_W-1:0]    enq_prs2,
  input  logic [PREG_W-1:0]    enq_prd,
  input  logic                 enq_src1_state,
  input  logic                 enq_src2_state,
  input  logic                 enq_robidx_flag,
  input  logic [ROB_W-1:0]     enq_robidx,
  input  logic                 wb0_valid,
  input  logic [PREG_W-1:0]    wb0_prd,
  input  logic                 wb1_valid,
  input  logic [PREG_W-1:0]    wb1_prd,
  output logic                 iss_valid,
  input  logic                 iss_ready,
  output logic [PAYLOAD_W-1:0] iss_payload,
  output logic [PREG_W-1:0]    iss_prs1,
  output logic [PREG_W-1:0]    iss_prs2,
  output logic [PREG_W-1:0]    iss_prd,
  output logic                 iss_src1_is_reg,
  output logic                 iss_src2_is_reg,
  output logic                 iss_robidx_flag,
  output logic [ROB_W-1:0]     iss_robidx,
  input  logic                 flush_valid,
  input  logic                 flush_robidx_flag,
  input  logic [ROB_W-1:0]     flush_robidx
);

  localparam int IDX_W = $clog2(DEPTH);

  isq_entry_t r_q [DEPTH];

  logic [DEPTH-1:0] w_older [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] w_kill;
  logic [DEPTH-1:0] w_alloc_oh;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_has_free;
  logic             w_any_rdy;
  logic             w_enq_fire;
  logic             w_iss_fire;
  logic             w_bypass;
  logic             w_alloc;
  logic             w_free_sel;
  isq_entry_t       w_new;
  isq_entry_t       w_iss;

  // w_older[i][j]: entry i is older than entry j; also a flush mask per entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_pair
      if (gi == gj) begin : g_diag
        assign w_older[gi][gj] = 1'b0;
      end else begin : g_cmp
        robidx_older_cmp u_cmp (
          .i_a_flag (r_q[gi].robidx_flag),
          .i_a_idx  (r_q[gi].robidx),
          .i_b_flag (r_q[gj].robidx_flag),
          .i_b_idx  (r_q[gj].robidx),
          .o_older  (w_older[gi][gj])
        );
      end
    end
    robidx_older_cmp u_flush_cmp (
      .i_a_flag (flush_robidx_flag),
      .i_a_idx  (flush_robidx),
      .i_b_flag (r_q[gi].robidx_flag),
      .i_b_idx  (r_q[gi].robidx),
      .o_older  (w_kill[gi])
    );
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_q[i].valid;
      w_rdy[i]   = r_q[i].valid & r_q[i].rdy1 & r_q[i].rdy2;
    end
  end

  // An entry wins unless another ready entry is older (slot index breaks an impossible tie).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_sel[i] = w_rdy[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && w_rdy[j] && !w_older[i][j] && (w_older[j][i] || (j < i)))
          w_sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_sel_idx  = '0;
    w_alloc_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_sel[i]) w_sel_idx = IDX_W'(i);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_alloc_oh    = '0;
        w_alloc_oh[i] = 1'b1;
      end
    end
  end

  assign w_has_free = ~(&w_valid);
  assign w_any_rdy  = |w_rdy;

  always_comb begin
    w_new             = '0;
    w_new.valid       = 1'b1;
    w_new.rdy1        = src_ready_at_enq(enq_src1_is_reg, enq_prs1, enq_src1_state,
                                         wb0_valid, wb0_prd, wb1_valid, wb1_prd);
    w_new.rdy2        = src_ready_at_enq(enq_src2_is_reg, enq_prs2, enq_src2_state,
                                         wb0_valid, wb0_prd, wb1_valid, wb1_prd);
    w_new.src1_is_reg = enq_src1_is_reg;
    w_new.src2_is_reg = enq_src2_is_reg;
    w_new.prs1        = enq_prs1;
    w_new.prs2        = enq_prs2;
    w_new.prd         = enq_prd;
    w_new.robidx_flag = enq_robidx_flag;
    w_new.robidx      = enq_robidx;
    w_new.payload     = enq_payload;
  end

  assign enq_ready  = ~reset & w_has_free & ~flush_valid;
  assign w_enq_fire = enq_valid & enq_ready;

`ifdef ISQ_BYPASS_EN
  assign w_bypass = w_enq_fire & ~(|w_valid) & w_new.rdy1 & w_new.rdy2;
`else
  assign w_bypass = 1'b0;
`endif

  assign iss_valid  = ~reset & ~flush_valid & (w_any_rdy | w_bypass);
  assign w_iss_fire = iss_valid & iss_ready;
  assign w_alloc    = w_enq_fire & ~(w_bypass & iss_ready);
  assign w_free_sel = w_iss_fire & ~w_bypass;

  always_comb begin
    w_iss = w_bypass ? w_new : r_q[w_sel_idx];
  end

  assign iss_payload     = w_iss.payload;
  assign iss_prs1        = w_iss.prs1;
  assign iss_prs2        = w_iss.prs2;
  assign iss_prd         = w_iss.prd;
  assign iss_src1_is_reg = w_iss.src1_is_reg;
  assign iss_src2_is_reg = w_iss.src2_is_reg;
  assign iss_robidx_flag = w_iss.robidx_flag;
  assign iss_robidx      = w_iss.robidx;

  // Later assignments win: allocation only ever targets a slot that is empty this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((wb0_valid && (wb0_prd == r_q[i].prs1)) || (wb1_valid && (wb1_prd == r_q[i].prs1)))
          r_q[i].rdy1 <= 1'b1;
        if ((wb0_valid && (wb0_prd == r_q[i].prs2)) || (wb1_valid && (wb1_prd == r_q[i].prs2)))
          r_q[i].rdy2 <= 1'b1;
        if (flush_valid && w_kill[i]) r_q[i].valid <= 1'b0;
        if (w_free_sel && w_sel[i])   r_q[i].valid <= 1'b0;
        if (w_alloc && w_alloc_oh[i]) r_q[i] <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue (default build): reset, latency, wakeup, full, wrap order, flush.
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  logic                 clock;
  logic                 reset;
  logic                 enq_valid;
  logic                 enq_ready;
  logic [PAYLOAD_W-1:0] enq_payload;
  logic                 enq_src1_is_reg;
  logic                 enq_src2_is_reg;
  logic [PREG_W-1:0]    enq_prs1;
  logic [PREG_W-1:0]    enq_prs2;
  logic [PREG_W-1:0]    enq_prd;
  logic                 enq_src1_state;
  logic                 enq_src2_state;
  logic                 enq_robidx_flag;
  logic [ROB_W-1:0]     enq_robidx;
  logic                 wb0_valid;
  logic [PREG_W-1:0]    wb0_prd;
  logic                 wb1_valid;
  logic [PREG_W-1:0]    wb1_prd;
  logic                 iss_valid;
  logic                 iss_ready;
  logic [PAYLOAD_W-1:0] iss_payload;
  logic [PREG_W-1:0]    iss_prs1;
  logic [PREG_W-1:0]    iss_prs2;
  logic [PREG_W-1:0]    iss_prd;
  logic                 iss_src1_is_reg;
  logic                 iss_src2_is_reg;
  logic                 iss_robidx_flag;
  logic [ROB_W-1:0]     iss_robidx;
  logic                 flush_valid;
  logic                 flush_robidx_flag;
  logic [ROB_W-1:0]     flush_robidx;

  int checks = 0;
  int errors = 0;

  int_issue_queue dut (
    .clock             (clock),
    .reset             (reset),
    .enq_valid         (enq_valid),
    .enq_ready         (enq_ready),
    .enq_payload       (enq_payload),
    .enq_src1_is_reg   (enq_src1_is_reg),
    .enq_src2_is_reg   (enq_src2_is_reg),
    .enq_prs1          (enq_prs1),
    .enq_prs2          (enq_prs2),
    .enq_prd           (enq_prd),
    .enq_src1_state    (enq_src1_state),
    .enq_src2_state    (enq_src2_state),
    .enq_robidx_flag   (enq_robidx_flag),
    .enq_robidx        (enq_robidx),
    .wb0_valid         (wb0_valid),
    .wb0_prd           (wb0_prd),
    .wb1_valid         (wb1_valid),
    .wb1_prd           (wb1_prd),
    .iss_valid         (iss_valid),
    .iss_ready         (iss_ready),
    .iss_payload       (iss_payload),
    .iss_prs1          (iss_prs1),
    .iss_prs2          (iss_prs2),
    .iss_prd           (iss_prd),
    .iss_src1_is_reg   (iss_src1_is_reg),
    .iss_src2_is_reg   (iss_src2_is_reg),
    .iss_robidx_flag   (iss_robidx_flag),
    .iss_robidx        (iss_robidx),
    .flush_valid       (flush_valid),
    .flush_robidx_flag (flush_robidx_flag),
    .flush_robidx      (flush_robidx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [PAYLOAD_W-1:0] pl(input logic f, input logic [ROB_W-1:0] idx);
    return {24{1'b0, f, idx}};
  endfunction

  task automatic chk(input string tag, input logic [PAYLOAD_W-1:0] obs, input logic [PAYLOAD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    enq_valid = 1'b0; enq_payload = '0; enq_src1_is_reg = 1'b0; enq_src2_is_reg = 1'b0;
    enq_prs1 = '0; enq_prs2 = '0; enq_prd = '0; enq_src1_state = 1'b0; enq_src2_state = 1'b0;
    enq_robidx_flag = 1'b0; enq_robidx = '0;
    wb0_valid = 1'b0; wb0_prd = '0; wb1_valid = 1'b0; wb1_prd = '0;
    flush_valid = 1'b0; flush_robidx_flag = 1'b0; flush_robidx = '0;
  endtask

  task automatic enq(input logic f, input logic [ROB_W-1:0] idx,
                     input logic s1reg, input logic [PREG_W-1:0] p1, input logic st1,
                     input logic s2reg, input logic [PREG_W-1:0] p2, input logic st2);
    enq_valid = 1'b1; enq_payload = pl(f, idx); enq_robidx_flag = f; enq_robidx = idx;
    enq_src1_is_reg = s1reg; enq_prs1 = p1; enq_src1_state = st1;
    enq_src2_is_reg = s2reg; enq_prs2 = p2; enq_src2_state = st2;
    enq_prd = idx;
  endtask

  task automatic enq_rdy(input logic f, input logic [ROB_W-1:0] idx);
    enq(f, idx, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    idle();
    iss_ready = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_enq_ready", enq_ready, 0);
    chk("rst_iss_valid", iss_valid, 0);
    tick(); tick();
    reset = 1'b0;
    #2;
    chk("post_rst_enq_ready", enq_ready, 1);
    chk("post_rst_iss_valid", iss_valid, 0);
    tick();

    // ready sources: issue the cycle after enqueue
    enq_rdy(1'b0, 6'd3); iss_ready = 1'b1;
    #2;
    chk("lat_enq_ready", enq_ready, 1);
    chk("lat_no_same_cycle", iss_valid, 0);
    tick(); idle();
    #2;
    chk("lat_iss_valid", iss_valid, 1);
    chk("lat_iss_robidx", iss_robidx, 3);
    chk("lat_iss_payload", iss_payload, pl(1'b0, 6'd3));
    chk("lat_iss_prd", iss_prd, 3);
    tick();
    #2;
    chk("lat_empty_after", iss_valid, 0);

    // prs1=12 not ready; wakeup two cycles later
    enq(1'b0, 6'd10, 1'b1, 6'd12, 1'b0, 1'b0, 6'd0, 1'b0);
    tick(); idle();
    wb1_valid = 1'b1; wb1_prd = 6'd13;
    #2;
    chk("wake_wait", iss_valid, 0);
    tick(); idle();
    wb0_valid = 1'b1; wb0_prd = 6'd12;
    #2;
    chk("wake_not_same_cycle", iss_valid, 0);
    tick(); idle();
    #2;
    chk("wake_iss_valid", iss_valid, 1);
    chk("wake_iss_robidx", iss_robidx, 10);
    chk("wake_iss_prs1", iss_prs1, 12);
    chk("wake_iss_src1_is_reg", iss_src1_is_reg, 1);
    tick();
    #2;
    chk("wake_empty_after", iss_valid, 0);

    // prs1 = preg 0, prs2 captured from a writeback in the enqueue cycle
    enq(1'b0, 6'd40, 1'b1, 6'd0, 1'b0, 1'b1, 6'd20, 1'b0);
    wb1_valid = 1'b1; wb1_prd = 6'd20;
    tick(); idle();
    #2;
    chk("enqwb_iss_valid", iss_valid, 1);
    chk("enqwb_iss_robidx", iss_robidx, 40);
    chk("enqwb_iss_prs2", iss_prs2, 20);
    chk("enqwb_iss_src2_is_reg", iss_src2_is_reg, 1);
    tick();
    #2;
    chk("enqwb_empty_after", iss_valid, 0);

    // fill all 8 slots while execute stalls
    iss_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      enq_rdy(1'b0, 6'(20 + k));
      #2;
      chk("fill_enq_ready", enq_ready, 1);
      if (k > 0) chk("fill_hold_robidx", iss_robidx, 20);
      tick();
    end
    enq_rdy(1'b0, 6'd28);
    #2;
    chk("full_enq_ready", enq_ready, 0);
    chk("full_iss_valid", iss_valid, 1);
    chk("full_iss_robidx", iss_robidx, 20);
    tick();
    iss_ready = 1'b1;
    #2;
    chk("full_no_same_cycle_free", enq_ready, 0);
    chk("full_iss_robidx2", iss_robidx, 20);
    tick();
    iss_ready = 1'b0;
    #2;
    chk("free_next_enq_ready", enq_ready, 1);
    chk("free_next_iss_robidx", iss_robidx, 21);
    tick(); idle();
    #2;
    chk("refull_enq_ready", enq_ready, 0);
    tick();
    iss_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #2;
      chk("drain_iss_valid", iss_valid, 1);
      chk("drain_iss_robidx", iss_robidx, 6'(21 + k));
      tick();
    end
    #2;
    chk("drain_empty", iss_valid, 0);

    // rob wrap ordering
    iss_ready = 1'b0;
    enq_rdy(1'b1, 6'd1);
    tick();
    enq_rdy(1'b0, 6'd62);
    #2;
    chk("wrap_only_entry", iss_robidx, 1);
    tick();
    enq_rdy(1'b0, 6'd60);
    #2;
    chk("wrap_62_before_1", iss_robidx, 62);
    tick(); idle();
    iss_ready = 1'b1;
    #2;
    chk("wrap_first_idx", iss_robidx, 60);
    chk("wrap_first_flag", iss_robidx_flag, 0);
    tick();
    #2;
    chk("wrap_second_idx", iss_robidx, 62);
    chk("wrap_second_flag", iss_robidx_flag, 0);
    tick();
    #2;
    chk("wrap_third_idx", iss_robidx, 1);
    chk("wrap_third_flag", iss_robidx_flag, 1);
    tick();
    #2;
    chk("wrap_empty", iss_valid, 0);

    // flush at robidx 5: keep 4 (woken during flush) and 5, drop 7 and 9
    iss_ready = 1'b0;
    enq(1'b0, 6'd4, 1'b1, 6'd33, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    enq_rdy(1'b0, 6'd5); tick();
    enq_rdy(1'b0, 6'd7); tick();
    enq_rdy(1'b0, 6'd9); tick();
    idle();
    #2;
    chk("pre_flush_iss_valid", iss_valid, 1);
    chk("pre_flush_iss_robidx", iss_robidx, 5);
    tick();
    flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = 6'd5;
    enq_rdy(1'b0, 6'd11);
    wb0_valid = 1'b1; wb0_prd = 6'd33;
    iss_ready = 1'b1;
    #2;
    chk("flush_iss_valid", iss_valid, 0);
    chk("flush_enq_ready", enq_ready, 0);
    tick(); idle();
    #2;
    chk("flush_keep_4_valid", iss_valid, 1);
    chk("flush_keep_4", iss_robidx, 4);
    tick();
    #2;
    chk("flush_keep_5", iss_robidx, 5);
    tick();
    #2;
    chk("flush_dropped_young", iss_valid, 0);
    chk("flush_enq_ready_after", enq_ready, 1);

    // reset mid-run with 5 valid entries
    iss_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      enq_rdy(1'b0, 6'(50 + k));
      tick();
    end
    idle();
    #2;
    chk("midrst_pre_iss_valid", iss_valid, 1);
    chk("midrst_pre_iss_robidx", iss_robidx, 50);
    tick();
    reset = 1'b1;
    #2;
    chk("midrst_enq_ready", enq_ready, 0);
    chk("midrst_iss_valid", iss_valid, 0);
    tick();
    reset = 1'b0; iss_ready = 1'b1;
    #2;
    chk("midrst_after_iss_valid", iss_valid, 0);
    chk("midrst_after_enq_ready", enq_ready, 1);
    tick();
    #2;
    chk("midrst_no_stale", iss_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
